// File: rtl/fg_packet_sink.sv
// Packet sink: takes a destination header followed by an AXI-stream payload and
// reports one descriptor (dest, byte length, error flags) per packet, plus running stats.
module fg_packet_sink #(
   parameter int DEST_WIDTH = 8,
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  input_hdr_valid,
   output logic                  input_hdr_ready,
   input  logic [DEST_WIDTH-1:0] input_hdr_dest,

   input  logic [DATA_WIDTH-1:0] input_payload_tdata,
   input  logic [KEEP_WIDTH-1:0] input_payload_tkeep,
   input  logic                  input_payload_tvalid,
   output logic                  input_payload_tready,
   input  logic                  input_payload_tlast,
   input  logic                  input_payload_tuser,

   output logic                  output_pd_valid,
   input  logic                  output_pd_ready,
   output logic [DEST_WIDTH-1:0] output_pd_dest,
   output logic [31:0]           output_pd_len,
   output logic [2:0]            output_pd_err,

   output logic                  busy,
   output logic [31:0]           packet_count,
   output logic [63:0]           byte_count,
   output logic [31:0]           error_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      REPORT  = 2'd2
   } state_t;

   state_t state, state_next;

   logic                  ready_en;
   logic [DEST_WIDTH-1:0] dest_q;
   logic [31:0]           len_q;
   logic [2:0]            err_q;

   logic                  hdr_fire;
   logic                  beat_fire;
   logic [31:0]           keep_bytes;
   logic [32:0]           len_sum;
   logic [31:0]           len_new;
   logic [KEEP_WIDTH:0]   keep_inc;
   logic                  keep_full;
   logic                  keep_contig;
   logic                  keep_bad;
   logic [2:0]            err_new;

   // Payload data is not inspected, only counted.
   logic unused_tdata;
   assign unused_tdata = ^input_payload_tdata;

   function automatic logic [31:0] popcount(input logic [KEEP_WIDTH-1:0] v);
      logic [31:0] n;
      n = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
         n = n + {31'd0, v[i]};
      end
      return n;
   endfunction

   assign hdr_fire  = input_hdr_valid && input_hdr_ready;
   assign beat_fire = input_payload_tvalid && input_payload_tready;

   assign keep_bytes = popcount(input_payload_tkeep);
   assign len_sum    = {1'b0, len_q} + {1'b0, keep_bytes};
   assign len_new    = len_sum[32] ? 32'hFFFF_FFFF : len_sum[31:0];

   // A mask is contiguous from bit 0 exactly when adding one clears every set bit.
   assign keep_inc    = {1'b0, input_payload_tkeep} + {{KEEP_WIDTH{1'b0}}, 1'b1};
   assign keep_full   = &input_payload_tkeep;
   assign keep_contig = (input_payload_tkeep != '0) &&
                        (({1'b0, input_payload_tkeep} & keep_inc) == '0);
   assign keep_bad    = input_payload_tlast ? !keep_contig : !keep_full;

   assign err_new = {err_q[2] | len_sum[32],
                     err_q[1] | keep_bad,
                     err_q[0] | (input_payload_tlast & input_payload_tuser)};

   // NOTE: every output of this block gets a default before the case so no latches are inferred.
   always_comb begin
      state_next           = state;
      input_hdr_ready      = 1'b0;
      input_payload_tready = 1'b0;
      output_pd_valid      = 1'b0;
      case (state)
         IDLE: begin
            input_hdr_ready = ready_en;
            if (input_hdr_valid && ready_en) state_next = PAYLOAD;
         end
         PAYLOAD: begin
            input_payload_tready = 1'b1;
            if (input_payload_tvalid && input_payload_tlast) state_next = REPORT;
         end
         REPORT: begin
            output_pd_valid = 1'b1;
            if (output_pd_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ready_en <= 1'b0;
      end else begin
         state    <= state_next;
         ready_en <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dest_q         <= '0;
         len_q          <= '0;
         err_q          <= '0;
         output_pd_dest <= '0;
         output_pd_len  <= '0;
         output_pd_err  <= '0;
         packet_count   <= '0;
         byte_count     <= '0;
         error_count    <= '0;
      end else begin
         if (hdr_fire) begin
            dest_q <= input_hdr_dest;
            len_q  <= '0;
            err_q  <= '0;
         end
         if (beat_fire) begin
            len_q <= len_new;
            err_q <= err_new;
            // Descriptor and stats are captured together on the closing beat.
            if (input_payload_tlast) begin
               output_pd_dest <= dest_q;
               output_pd_len  <= len_new;
               output_pd_err  <= err_new;
               packet_count   <= packet_count + 32'd1;
               byte_count     <= byte_count + {32'd0, len_new};
               if (|err_new) error_count <= error_count + 32'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fg_packet_sink.sv
// Self-checking bench for fg_packet_sink: directed vector table, multi-cycle corner
// sequences and randomized packets checked against a per-packet reference model.
module tb_fg_packet_sink;

   logic        clk = 1'b0;
   logic        rst;
   logic        hdr_valid;
   logic        hdr_ready;
   logic [7:0]  hdr_dest;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tvalid;
   logic        tready;
   logic        tlast;
   logic        tuser;
   logic        pd_valid;
   logic        pd_ready;
   logic [7:0]  pd_dest;
   logic [31:0] pd_len;
   logic [2:0]  pd_err;
   logic        busy;
   logic [31:0] packet_count;
   logic [63:0] byte_count;
   logic [31:0] error_count;

   int checks = 0;
   int errors = 0;

   longint exp_pkts  = 0;
   longint exp_bytes = 0;
   longint exp_errs  = 0;

   always #5 clk = ~clk;

   fg_packet_sink #(.DEST_WIDTH(8), .DATA_WIDTH(64), .KEEP_WIDTH(8)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .input_hdr_valid      (hdr_valid),
      .input_hdr_ready      (hdr_ready),
      .input_hdr_dest       (hdr_dest),
      .input_payload_tdata  (tdata),
      .input_payload_tkeep  (tkeep),
      .input_payload_tvalid (tvalid),
      .input_payload_tready (tready),
      .input_payload_tlast  (tlast),
      .input_payload_tuser  (tuser),
      .output_pd_valid      (pd_valid),
      .output_pd_ready      (pd_ready),
      .output_pd_dest       (pd_dest),
      .output_pd_len        (pd_len),
      .output_pd_err        (pd_err),
      .busy                 (busy),
      .packet_count         (packet_count),
      .byte_count           (byte_count),
      .error_count          (error_count)
   );

   typedef struct {
      logic [7:0]  dest;
      int          nbeats;
      logic [31:0] keeps;   // beat i keep mask in keeps[8*i +: 8]
      logic [3:0]  user;    // beat i tuser in user[i]
      logic [31:0] exp_len;
      logic [2:0]  exp_err;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic check_counters(input string name);
      check({name, " packet_count"}, packet_count, exp_pkts);
      check({name, " byte_count"}, byte_count, exp_bytes);
      check({name, " error_count"}, error_count, exp_errs);
   endtask

   task automatic send_hdr(input logic [7:0] d);
      int n = 0;
      hdr_valid = 1'b1;
      hdr_dest  = d;
      while (!hdr_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) timeout("hdr_accept");
      @(negedge clk);
      hdr_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [7:0] k, input logic last, input logic user, input int stall);
      int n = 0;
      repeat (stall) @(negedge clk);
      tkeep  = k;
      tlast  = last;
      tuser  = user;
      tdata  = {$urandom, $urandom};
      tvalid = 1'b1;
      while (!tready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) timeout("beat_accept");
      @(negedge clk);
      tvalid = 1'b0;
      tlast  = 1'b0;
      tuser  = 1'b0;
   endtask

   task automatic recv_desc(input string name, input logic [7:0] d, input logic [31:0] len,
                            input logic [2:0] err, input int stall);
      int n = 0;
      while (!pd_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) timeout({name, " pd_valid"});
      check({name, " dest"}, pd_dest, d);
      check({name, " len"}, pd_len, len);
      check({name, " err"}, pd_err, err);
      exp_pkts++;
      exp_bytes += len;
      if (err != 3'b000) exp_errs++;
      check_counters(name);
      repeat (stall) @(negedge clk);
      pd_ready = 1'b1;
      @(negedge clk);
      pd_ready = 1'b0;
   endtask

   initial begin
      logic [7:0]  d;
      logic [7:0]  k;
      logic        last;
      logic        user;
      logic [31:0] len;
      logic [2:0]  err;
      int          nb;
      int          cnt;
      longint      base_pkts;
      longint      base_bytes;
      longint      rand_sum;

      rst       = 1'b1;
      hdr_valid = 1'b0;
      hdr_dest  = '0;
      tdata     = '0;
      tkeep     = '0;
      tvalid    = 1'b0;
      tlast     = 1'b0;
      tuser     = 1'b0;
      pd_ready  = 1'b0;

      vecs[0] = '{8'h05, 4, 32'h0FFF_FFFF, 4'b0000, 32'd28, 3'b000};
      vecs[1] = '{8'hA1, 1, 32'h0000_00FF, 4'b0001, 32'd8,  3'b001};
      vecs[2] = '{8'h3C, 3, 32'h000B_7FFF, 4'b0000, 32'd18, 3'b010};
      vecs[3] = '{8'h00, 1, 32'h0000_0000, 4'b0000, 32'd0,  3'b010};
      vecs[4] = '{8'hFF, 2, 32'h0000_01FF, 4'b0001, 32'd9,  3'b000};
      vecs[5] = '{8'h77, 2, 32'h0000_FF0F, 4'b0010, 32'd12, 3'b011};
      vecs[6] = '{8'h12, 1, 32'h0000_003F, 4'b0000, 32'd6,  3'b000};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst hdr_ready", hdr_ready, 0);
      check("rst tready", tready, 0);
      check("rst pd_valid", pd_valid, 0);
      check("rst pd_dest", pd_dest, 0);
      check("rst pd_len", pd_len, 0);
      check("rst pd_err", pd_err, 0);
      check("rst busy", busy, 0);
      check_counters("rst");
      rst = 1'b0;
      #1;
      check("post-rst hdr_ready before edge", hdr_ready, 0);
      @(negedge clk);
      check("post-rst hdr_ready after edge", hdr_ready, 1);

      // Payload offered in IDLE must be held off
      tkeep  = 8'hFF;
      tlast  = 1'b1;
      tvalid = 1'b1;
      repeat (3) begin
         check("idle tready", tready, 0);
         @(negedge clk);
      end
      tvalid = 1'b0;
      tlast  = 1'b0;
      check("idle no consume", packet_count, 0);

      // Directed vector table
      for (int v = 0; v < 7; v++) begin
         send_hdr(vecs[v].dest);
         check("payload busy", busy, 1);
         for (int b = 0; b < vecs[v].nbeats; b++) begin
            send_beat(vecs[v].keeps[8*b +: 8], b == vecs[v].nbeats - 1, vecs[v].user[b], b % 2);
         end
         recv_desc($sformatf("vec%0d", v), vecs[v].dest, vecs[v].exp_len, vecs[v].exp_err, v % 3);
      end

      // Descriptor back-pressure with a second header pending
      send_hdr(8'h44);
      send_beat(8'hFF, 1'b1, 1'b0, 0);
      hdr_valid = 1'b1;
      hdr_dest  = 8'h55;
      for (int i = 0; i < 10; i++) begin
         check("hold pd_valid", pd_valid, 1);
         check("hold pd_dest", pd_dest, 8'h44);
         check("hold pd_len", pd_len, 8);
         check("hold pd_err", pd_err, 0);
         check("hold hdr_ready", hdr_ready, 0);
         @(negedge clk);
      end
      pd_ready = 1'b1;
      @(negedge clk);
      pd_ready = 1'b0;
      exp_pkts++;
      exp_bytes += 8;
      check("after handshake pd_valid", pd_valid, 0);
      check("after handshake hdr_ready", hdr_ready, 1);
      @(negedge clk);
      hdr_valid = 1'b0;
      check("second hdr accepted busy", busy, 1);
      check("second hdr accepted tready", tready, 1);
      send_beat(8'h07, 1'b1, 1'b0, 0);
      recv_desc("second", 8'h55, 32'd3, 3'b000, 0);

      // Reset in the middle of a packet
      send_hdr(8'h66);
      send_beat(8'hFF, 1'b0, 1'b0, 0);
      send_beat(8'hFF, 1'b0, 1'b0, 0);
      rst = 1'b1;
      #1;
      exp_pkts  = 0;
      exp_bytes = 0;
      exp_errs  = 0;
      check("midrst hdr_ready", hdr_ready, 0);
      check("midrst tready", tready, 0);
      check("midrst pd_valid", pd_valid, 0);
      check("midrst pd_dest", pd_dest, 0);
      check("midrst pd_len", pd_len, 0);
      check("midrst pd_err", pd_err, 0);
      check("midrst busy", busy, 0);
      check_counters("midrst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post midrst hdr_ready", hdr_ready, 1);
      check("post midrst pd_valid", pd_valid, 0);
      send_hdr(8'h09);
      send_beat(8'h03, 1'b1, 1'b0, 0);
      recv_desc("post midrst", 8'h09, 32'd2, 3'b000, 1);

      // Randomized packets against the reference model
      base_pkts  = exp_pkts;
      base_bytes = exp_bytes;
      rand_sum   = 0;
      for (int p = 0; p < 100; p++) begin
         nb  = $urandom_range(1, 5);
         d   = 8'($urandom);
         len = '0;
         err = '0;
         send_hdr(d);
         for (int b = 0; b < nb; b++) begin
            last = (b == nb - 1);
            if (last) begin
               k = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'((1 << $urandom_range(1, 8)) - 1);
            end else begin
               k = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'hFF;
            end
            user = ($urandom_range(0, 5) == 0);
            cnt  = $countones(k);
            len  = len + 32'(cnt);
            if (!last && k != 8'hFF) err[1] = 1'b1;
            if (last && (k == 8'h00 || int'(k) != (1 << cnt) - 1)) err[1] = 1'b1;
            if (last && user) err[0] = 1'b1;
            send_beat(k, last, user, $urandom_range(0, 3));
         end
         rand_sum += len;
         recv_desc($sformatf("rand%0d", p), d, len, err, $urandom_range(0, 5));
      end
      check("rand packet_count delta", 64'(packet_count) - 64'(base_pkts), 100);
      check("rand byte_count delta", byte_count - 64'(base_bytes), 64'(rand_sum));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
